fifo_umbrales: RTL and testbench
================================

Name: fifo_umbrales

Overview:
- Synchronous FIFO that sits directly upstream of the link-state FSM.
- Buffers one data lane and produces the `empty` flag that the FSM samples as one of its eight `empty_fifo_N` inputs.
- Generates `almost_full` and `almost_empty` flow-control flags from the low/high thresholds (`umbral_L_out`, `umbral_H_out`) that the FSM latches during INIT.
- Eight instances, one per lane, feed the FSM.

Parameters:
- DATA_WIDTH, 6 — width of one FIFO word.
- ADDR_WIDTH, 3 — pointer width; depth = 2**ADDR_WIDTH = 8 words.
- UMBRALES_L_H, 8 — threshold width; must match the FSM parameter.

Ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- reset  input  1  — asynchronous, active-high reset.
- umbral_L  input  UMBRALES_L_H  — almost-empty threshold, from FSM `umbral_L_out`.
- umbral_H  input  UMBRALES_L_H  — almost-full threshold, from FSM `umbral_H_out`.
- push  input  1  — write request.
- data_in  input  DATA_WIDTH  — write data.
- pop  input  1  — read request.
- data_out  output  DATA_WIDTH  — read data.
- valid_out  output  1  — `data_out` carries a popped word this cycle.
- empty  output  1  — count == 0; goes to FSM `empty_fifo_N`.
- full  output  1  — count == depth.
- almost_empty  output  1  — count <= umbral_L.
- almost_full  output  1  — count >= umbral_H and umbral_H != 0.
- error  output  1  — sticky overflow/underflow indicator.
- fifo_count  output  ADDR_WIDTH+1  — current occupancy, 0..depth.

Behaviour:
- Reset (async, active-high, acts immediately regardless of clk):
  - rd_ptr = wr_ptr = count = 0
  - data_out = 0, valid_out = 0, error = 0
  - Memory contents are not cleared.
  - Flags after reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless umbral_H = 0 — see masking rule below).
- Reset mid-operation: all buffered words are discarded and the pointers restart at 0. A push or pop in the reset cycle has no effect.
- Write: `push && !full` → mem[wr_ptr] <= data_in, wr_ptr++. Pointers wrap modulo depth through natural overflow of the ADDR_WIDTH counter.
- Read: `pop && !empty` → data_out <= mem[rd_ptr], rd_ptr++, valid_out <= 1 on the next edge. Read latency is one cycle. With no valid pop, valid_out <= 0 and data_out holds its last value.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous push + pop:
  - When full: both execute; count stays at depth.
  - When empty: push executes; the pop is ignored and counts as an underflow.
  - Otherwise: both execute.
- Overflow: `push && full && !pop` drops the word and sets error.
- Underflow: `pop && empty` is ignored and sets error.
- error stays high until reset.
- Flags are combinational from the registered count:
  - count is zero-extended to UMBRALES_L_H bits before comparison.
  - umbral_H > depth → almost_full never asserts.
  - umbral_L >= depth → almost_empty is always asserted.
  - umbral_H = 0 masks almost_full to 0; this covers the cycle before the FSM has loaded its thresholds.
- Threshold inputs may change on any cycle. The flags follow in the same cycle; no internal latching.
- No internal FSM beyond the pointer/count registers. The block is passive and has no knowledge of the link state.

Optional Feature:
- Macro: FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out = mem[rd_ptr] combinationally; valid_out = !empty.
  - A pop acknowledges the word currently shown on data_out. Read latency is 0.
  - Reset: valid_out = 0 because empty = 1; data_out shows mem[0].
- Undefined: registered one-cycle read latency as described in Behaviour.

Test Plan:
- Reset, then push 0x01..0x08 in consecutive cycles → fifo_count = 8, full = 1, empty = 0; a 9th push of 0x3F → error = 1, count stays 8.
- umbral_L = 2, umbral_H = 6; push 6 words → almost_full rises exactly when count reaches 6. Pop down to 2 → almost_empty rises at count 2; empty is still 0.
- Full FIFO, push 0x2A and pop on the same cycle → count stays 8; next cycle valid_out = 1 with the oldest word. 0x2A is read out eighth.
- Empty FIFO, push 0x15 and pop on the same cycle → count = 1, error = 1, valid_out = 0. The following pop returns 0x15 with one-cycle latency.
- Push 12 and pop 12 words interleaved so the pointers wrap past 7 → data comes out in order, count returns to 0, empty = 1.
- Assert reset asynchronously mid-stream with count = 5 → empty = 1, fifo_count = 0, valid_out = 0, error = 0 before the next clk edge. umbral_H = 0 → almost_full = 0.

Source files
------------

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: single-lane synchronous FIFO feeding the link-state FSM.
//
// Buffers one data lane, reports occupancy and produces empty/full plus
// threshold-based almost_empty/almost_full flow-control flags. Thresholds come
// straight from the FSM and are compared combinationally against the
// registered occupancy count, so flags follow threshold changes in the same
// cycle.
//
// Optional feature: define FIFO_FWFT_EN for first-word fall-through
// (data_out shows mem[rd_ptr] combinationally, valid_out = !empty). Without it,
// reads have one cycle of registered latency.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   umbral_L      almost-empty threshold (count <= umbral_L)
//   umbral_H      almost-full threshold (count >= umbral_H, masked when 0)
//   push, data_in write request and data
//   pop           read request
//   data_out      read data
//   valid_out     data_out carries a popped word
//   empty, full   occupancy == 0 / == depth
//   almost_empty, almost_full  threshold flags
//   error         sticky overflow/underflow, cleared only by reset
//   fifo_count    occupancy, 0..depth

module fifo_umbrales #(
    parameter int unsigned DATA_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned UMBRALES_L_H = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [UMBRALES_L_H-1:0] umbral_L,
    input  logic [UMBRALES_L_H-1:0] umbral_H,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     fifo_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     count;
    logic                    error_q;
    logic                    wr_en;
    logic                    rd_en;
    logic                    overflow;
    logic                    underflow;
    logic [UMBRALES_L_H-1:0] count_ext;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // A pop on a full FIFO frees a slot in the same cycle, so the push is kept.
    // A pop on an empty FIFO is never honoured, even alongside a push.
    assign wr_en     = push && (!full || pop);
    assign rd_en     = pop && !empty;
    assign overflow  = push && full && !pop;
    assign underflow = pop && empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (wr_en && !rd_en) begin
                count <= count + ONE_CNT;
            end else if (rd_en && !wr_en) begin
                count <= count - ONE_CNT;
            end
            if (overflow || underflow) begin
                error_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; the reset term only keeps a push in the reset
    // cycle from touching memory.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out  = mem[rd_ptr];
    assign valid_out = !empty;
`else
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                data_q <= mem[rd_ptr];
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
`endif

    // Out-of-range thresholds need no special casing: umbral_H > depth can
    // never be reached and umbral_L >= depth is always satisfied.
    assign count_ext    = UMBRALES_L_H'(count);
    assign almost_empty = (count_ext <= umbral_L);
    // umbral_H == 0 means the FSM has not loaded thresholds yet.
    assign almost_full  = (umbral_H != '0) && (count_ext >= umbral_H);

    assign error      = error_q;
    assign fifo_count = count;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed, table-driven bench for fifo_umbrales (default registered-read build).
module tb_fifo_umbrales;

    logic       clk;
    logic       reset;
    logic [7:0] umbral_L;
    logic [7:0] umbral_H;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       error;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;

    fifo_umbrales #(
        .DATA_WIDTH  (6),
        .ADDR_WIDTH  (3),
        .UMBRALES_L_H(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .umbral_L    (umbral_L),
        .umbral_H    (umbral_H),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .error       (error),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       push;
        logic       pop;
        logic [5:0] din;
        logic [7:0] ul;
        logic [7:0] uh;
        logic [3:0] cnt;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       err;
        logic       vld;
        logic [5:0] dout;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic p, input logic q,
                                input logic [5:0] din, input logic [7:0] ul,
                                input logic [7:0] uh, input logic [3:0] cnt,
                                input logic emp, input logic ful, input logic ae,
                                input logic af, input logic err, input logic vld,
                                input logic [5:0] dout);
        vec_t v;
        v.rst = rst; v.push = p; v.pop = q; v.din = din; v.ul = ul; v.uh = uh;
        v.cnt = cnt; v.emp = emp; v.ful = ful; v.ae = ae; v.af = af;
        v.err = err; v.vld = vld; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("fifo_count", idx, 32'(fifo_count), 32'(v.cnt));
        chk("empty", idx, 32'(empty), 32'(v.emp));
        chk("full", idx, 32'(full), 32'(v.ful));
        chk("almost_empty", idx, 32'(almost_empty), 32'(v.ae));
        chk("almost_full", idx, 32'(almost_full), 32'(v.af));
        chk("error", idx, 32'(error), 32'(v.err));
        chk("valid_out", idx, 32'(valid_out), 32'(v.vld));
        chk("data_out", idx, 32'(data_out), 32'(v.dout));
    endtask

    // Drive one cycle of stimulus and sample 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [5:0] d);
        push = p; pop = q; data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    function automatic logic [5:0] wdat(input int k);
        return 6'((k * 5 + 3) & 63);
    endfunction

    initial begin
        //            rst p q din    ul uh  cnt e f ae af er v dout
        vecs[0]  = mk(0, 1, 0, 6'h01, 2, 6, 1, 0, 0, 1, 0, 0, 0, 6'h00);
        vecs[1]  = mk(0, 1, 0, 6'h02, 2, 6, 2, 0, 0, 1, 0, 0, 0, 6'h00);
        vecs[2]  = mk(0, 1, 0, 6'h03, 2, 6, 3, 0, 0, 0, 0, 0, 0, 6'h00);
        vecs[3]  = mk(0, 1, 0, 6'h04, 2, 6, 4, 0, 0, 0, 0, 0, 0, 6'h00);
        vecs[4]  = mk(0, 1, 0, 6'h05, 2, 6, 5, 0, 0, 0, 0, 0, 0, 6'h00);
        vecs[5]  = mk(0, 1, 0, 6'h06, 2, 6, 6, 0, 0, 0, 1, 0, 0, 6'h00);
        vecs[6]  = mk(0, 1, 0, 6'h07, 2, 6, 7, 0, 0, 0, 1, 0, 0, 6'h00);
        vecs[7]  = mk(0, 1, 0, 6'h08, 2, 6, 8, 0, 1, 0, 1, 0, 0, 6'h00);
        // Overflow; out-of-range thresholds: H=9 never fires, L=8 always fires.
        vecs[8]  = mk(0, 1, 0, 6'h3F, 8, 9, 8, 0, 1, 1, 0, 1, 0, 6'h00);
        // Push+pop on full: count holds, oldest word comes out.
        vecs[9]  = mk(0, 1, 1, 6'h2A, 2, 6, 8, 0, 1, 0, 1, 1, 1, 6'h01);
        vecs[10] = mk(0, 0, 0, 6'h00, 2, 6, 8, 0, 1, 0, 1, 1, 0, 6'h01);
        vecs[11] = mk(0, 0, 1, 6'h00, 2, 6, 7, 0, 0, 0, 1, 1, 1, 6'h02);
        vecs[12] = mk(0, 0, 1, 6'h00, 2, 6, 6, 0, 0, 0, 1, 1, 1, 6'h03);
        vecs[13] = mk(0, 0, 1, 6'h00, 2, 6, 5, 0, 0, 0, 0, 1, 1, 6'h04);
        vecs[14] = mk(0, 0, 1, 6'h00, 2, 6, 4, 0, 0, 0, 0, 1, 1, 6'h05);
        vecs[15] = mk(0, 0, 1, 6'h00, 2, 6, 3, 0, 0, 0, 0, 1, 1, 6'h06);
        vecs[16] = mk(0, 0, 1, 6'h00, 2, 6, 2, 0, 0, 1, 0, 1, 1, 6'h07);
        vecs[17] = mk(0, 0, 1, 6'h00, 2, 6, 1, 0, 0, 1, 0, 1, 1, 6'h08);
        vecs[18] = mk(0, 0, 1, 6'h00, 2, 6, 0, 1, 0, 1, 0, 1, 1, 6'h2A);
        // Reset over an edge with a push: push ignored, state cleared.
        vecs[19] = mk(1, 1, 0, 6'h11, 2, 6, 0, 1, 0, 1, 0, 0, 0, 6'h00);
        // Push+pop on empty: push kept, pop is an underflow.
        vecs[20] = mk(0, 1, 1, 6'h15, 2, 6, 1, 0, 0, 1, 0, 1, 0, 6'h00);
        vecs[21] = mk(0, 0, 1, 6'h00, 2, 6, 0, 1, 0, 1, 0, 1, 1, 6'h15);

        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        umbral_L = 8'd2; umbral_H = 8'd6;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, mk(0, 0, 0, 0, 2, 6, 0, 1, 0, 1, 0, 0, 0, 6'h00));
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            reset = vecs[i].rst;
            umbral_L = vecs[i].ul;
            umbral_H = vecs[i].uh;
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            chk_all(i, vecs[i]);
            reset = 1'b0;
        end

        // Pointer wrap: 12 words streamed through with one in flight.
        umbral_L = 8'd2; umbral_H = 8'd6;
        step(1'b1, 1'b0, wdat(0));
        chk("wrap_count", 0, 32'(fifo_count), 32'd1);
        for (int k = 1; k < 12; k++) begin
            step(1'b1, 1'b1, wdat(k));
            chk("wrap_valid", k, 32'(valid_out), 32'd1);
            chk("wrap_data", k, 32'(data_out), 32'(wdat(k - 1)));
            chk("wrap_count", k, 32'(fifo_count), 32'd1);
        end
        step(1'b0, 1'b1, 6'h00);
        chk("wrap_data", 12, 32'(data_out), 32'(wdat(11)));
        chk("wrap_count", 12, 32'(fifo_count), 32'd0);
        chk("wrap_empty", 12, 32'(empty), 32'd1);

        // Fill to 5 with a word in flight, then exercise live thresholds.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 6'(k + 1));
        end
        step(1'b0, 1'b1, 6'h00);
        chk("pre_rst_count", 0, 32'(fifo_count), 32'd5);
        chk("pre_rst_valid", 0, 32'(valid_out), 32'd1);
        chk("pre_rst_data", 0, 32'(data_out), 32'h01);
        umbral_H = 8'd0;
        #1;
        chk("af_masked", 0, 32'(almost_full), 32'd0);
        umbral_H = 8'd3;
        #1;
        chk("af_live", 0, 32'(almost_full), 32'd1);
        umbral_H = 8'd0;
        #2;
        // Asynchronous reset between edges.
        reset = 1'b1;
        #1;
        chk("async_empty", 0, 32'(empty), 32'd1);
        chk("async_count", 0, 32'(fifo_count), 32'd0);
        chk("async_valid", 0, 32'(valid_out), 32'd0);
        chk("async_error", 0, 32'(error), 32'd0);
        chk("async_af", 0, 32'(almost_full), 32'd0);
        chk("async_ae", 0, 32'(almost_empty), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
